sync_dp_ram: RTL
================

# sync_dp_ram

Parametrised single-clock dual-port RAM: one write port with byte enables, one registered read port. It replaces the two-clock 8x16 RAM wherever both ports share a clock domain. It adds configurable width and depth, a selectable read-during-write mode, a read-valid strobe, and a hardware clear sequencer that sweeps every location after reset.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8
- ADDR_W, 3, address width in bits
- DEPTH, 8, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged)
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear sweep

- clk  in  1  single clock, rising edge
- clr_n  in  1  reset; synchronous, active-low
- we  in  1  write request
- wr_addr  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- be  in  DATA_W/8  byte enables; bit k covers data_in[8k+7:8k]
- re  in  1  read request
- rd_addr  in  ADDR_W  read address
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: data_out updated this cycle
- init_busy  out  1  clear sweep in progress; requests ignored
- addr_err  out  1  one-cycle strobe: an accepted request used an address ≥ DEPTH

## Operation
- FSM states: INIT, READY.
- clr_n low at a rising edge:
  - state ← INIT, sweep counter ← 0
  - data_out ← 0, rd_valid ← 0, addr_err ← 0, init_busy ← 1
  - memory is not written during the reset edge.
- INIT, with clr_n high:
  - each edge writes CLR_VAL to mem[counter], then counter ← counter+1.
  - After the write to DEPTH−1: state ← READY, init_busy ← 0.
- In INIT, we and re are ignored: no write, no rd_valid, no addr_err.
- READY, write: when we=1 and wr_addr < DEPTH, each byte k with be[k]=1 is updated. Bytes with be[k]=0 are unchanged. we=1 with be=0 is a legal no-op.
- READY, read: when re=1 and rd_addr < DEPTH, data_out ← mem[rd_addr] and rd_valid ← 1.
- data_out holds its value whenever no read completes.
- Out-of-range address (≥ DEPTH, possible only when DEPTH < 2^ADDR_W):
  - write: dropped
  - read: data_out ← 0, rd_valid ← 1
  - either case: addr_err ← 1 for one cycle.
- Same-cycle read and write to the same in-range address:
  - RDW_MODE=0: data_out gets the pre-write word.
  - RDW_MODE=1: data_out gets the post-write word, i.e. enabled bytes from data_in and the rest from memory.
  - Memory is updated in both modes.
- Read and write to different addresses in the same cycle are fully independent.
- Address counters do not wrap; addresses are used as given.

## Timing
- Read latency: 1 cycle. re sampled at edge N drives data_out and rd_valid=1 after edge N; rd_valid drops after edge N+1 unless re is held.
- Back-to-back reads: one word per cycle, rd_valid held high.
- Write visibility: a write at edge N is readable by a read sampled at edge N+1. In RDW_MODE=1 it is also visible at edge N.
- Clear sweep: clr_n released before edge R; INIT writes at edges R..R+DEPTH−1; init_busy is low after edge R+DEPTH−1. First accepted request is at edge R+DEPTH.
- Reset mid-sweep or mid-operation: takes effect at the next edge and restarts the sweep from address 0. A read sampled on a reset edge produces no rd_valid.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset and sweep, defaults: after release, init_busy stays high exactly 8 cycles. Then read addresses 0..7 → each data_out = 0x0000 with rd_valid high for 8 consecutive cycles.
- Byte enables:
  - write 0xABCD to addr 3 with be=2'b11, then 0x1234 with be=2'b01 → read addr 3 = 0xAB34
  - be=2'b00 write → read addr 3 still 0xAB34
- Read-during-write: addr 5 holds 0x1111; write 0x2222, be=2'b11, with a same-cycle read of addr 5.
  - RDW_MODE=0 → data_out 0x1111
  - RDW_MODE=1 → data_out 0x2222
  - next-cycle read → 0x2222 in both modes.
- Out-of-range, DEPTH=6, ADDR_W=3:
  - write 0xFFFF to addr 7 → addr_err pulses 1 cycle; no location is changed
  - read addr 6 → data_out 0, rd_valid 1, addr_err 1.
- Mid-sweep reset: drop clr_n 3 cycles into the sweep, release → init_busy high for the full 8 cycles again. A we/re issued during busy → no memory change, rd_valid stays 0.
- Streaming, DATA_W=32, ADDR_W=4, DEPTH=16, CLR_VAL=0xDEADBEEF:
  - read addr 9 after sweep → 0xDEADBEEF
  - write addr i = i·0x01010101 for i=0..15, then read all back-to-back → rd_valid high 16 cycles, values match.

Source files
------------

// File: rtl/sync_dp_ram.sv
// Single-clock dual-port RAM: byte-enabled write port, registered read port,
// and a post-reset sweep that fills every word with CLR_VAL.
module sync_dp_ram #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 3,
    parameter int                 DEPTH    = 8,
    parameter bit                 RDW_MODE = 1'b0,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  init_busy,
    output logic                  addr_err
);
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_we;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rdy, wr_in, rd_in, wr_ok, rd_ok, wr_bad, rd_bad;
    logic [DATA_W-1:0]   wr_mask, rd_word;

    assign rdy    = (state_q == READY);
    assign wr_in  = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in  = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_ok  = rdy & we & wr_in;
    assign rd_ok  = rdy & re & rd_in;
    assign wr_bad = rdy & we & ~wr_in;
    assign rd_bad = rdy & re & ~rd_in;

    // init_busy comes straight off the state flop, so it is registered
    assign init_busy = (state_q == INIT);

    for (genvar k = 0; k < NB; k++) begin : g_mask
        assign wr_mask[8*k +: 8] = {8{be[k]}};
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                if (cnt_q == LAST) state_d = READY;
                else               cnt_d   = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Memory array has no reset; the reset edge itself never writes it
    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (init_we) begin
                mem[cnt_q] <= CLR_VAL;
            end else if (wr_ok) begin
                for (int k = 0; k < NB; k++)
                    if (be[k]) mem[wr_addr][8*k +: 8] <= data_in[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE && wr_ok && (wr_addr == rd_addr))
            rd_word = (rd_word & ~wr_mask) | (data_in & wr_mask);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_ok | rd_bad;
            addr_err <= wr_bad | rd_bad;
            if (rd_ok)       data_out <= rd_word;
            else if (rd_bad) data_out <= '0;
        end
    end
endmodule
